serial_to_parallel_align: RTL and testbench
===========================================

Name: serial_to_parallel_align

Overview:
- Receive-side counterpart of the serialization stage. Consumes one serial lane produced by a parallel-to-serial stage: MSB-first bytes at one bit per clk_8f, with idle filled by the comma byte 0xBC.
- Finds the byte boundary, locks after a run of consecutive commas, then presents recovered bytes in parallel with a one-cycle valid strobe.
- Two instances (lane 0 and lane 1) sit directly after the serialization outputs in the link loopback.

Parameters:
- COMMA, 8'hBC, idle/alignment byte value.
- LOCK_CNT, 4, consecutive aligned COMMA bytes needed to enter ACTIVE (range 1..15).

Ports:
- clk_8f  input  1  bit clock; every register is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit stream, MSB first, one bit per clk_8f.
- data_out  output  8  last recovered data byte; held between strobes.
- valid_out  output  1  one-cycle strobe: data_out was updated with a non-comma byte.
- active  output  1  high while the FSM is in ACTIVE.

Behaviour:
- Reset (sampled at a clk_8f edge with reset=1):
  - Outputs: data_out=8'h00, valid_out=0, active=0.
  - Internal: shift register sr=8'h00, bit counter=0, lock counter=0, state=UNALIGNED.
  - Reset overrides all other activity, including mid-word and in ACTIVE.
- Shift: every non-reset edge, sr <= {sr[6:0], data_in}. "sr" below means the registered value after that edge.
- Word boundary: a cycle in which sr holds a complete aligned byte. Boundaries recur every 8 clocks, counted by a 3-bit wrap-around counter (7→0).
- State UNALIGNED:
  - Each cycle, compare sr to COMMA (sliding bit-level search).
  - On match: this cycle becomes a boundary; the bit counter restarts so the next boundary is 8 clocks later; lock counter=1; go to ALIGNING.
  - If LOCK_CNT==1, go directly to ACTIVE instead.
- State ALIGNING:
  - Evaluated only at boundaries.
  - sr==COMMA: increment the lock counter. When it reaches LOCK_CNT, go to ACTIVE.
  - sr!=COMMA: lock counter=0, return to UNALIGNED. The search resumes on the next cycle.
- State ACTIVE:
  - At each boundary, if sr!=COMMA: data_out<=sr and valid_out=1 for exactly one cycle. This is the edge after the boundary cycle, so latency is 1 clock from the last bit entering sr.
  - If sr==COMMA: valid_out stays 0 and data_out is held.
  - ACTIVE is left only by reset. There is no loss-of-lock detection.
- active is registered and goes high on the edge that enters ACTIVE.
- valid_out is never 1 outside ACTIVE.
- A byte equal to COMMA can never be delivered as data.
- Minimum lock time from the first comma bit: 8*LOCK_CNT clocks (32 at default).

Optional Feature:
- Macro: S2P_IDLE_CNT_EN.
- Defined:
  - Adds output idle_cnt [7:0], reset to 0.
  - Increments by 1 at every ACTIVE boundary where sr==COMMA, saturating at 8'hFF (no wrap).
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=1 for 3 clocks with random data_in → data_out=00, valid_out=0, active=0 throughout and on the first clock after release.
- Aligned lock: send BC,BC,BC,BC,A5,3C → active=1 on the edge after the 4th BC completes. valid_out pulses exactly twice, 8 clocks apart, with data_out=A5 then 3C. No pulse during the BCs.
- Misaligned start: send 3 junk bits (1,0,1), then BC x4 and 5A → same lock point relative to the first BC; data_out=5A with a single strobe.
- Broken lock: send BC,BC,BC,77,BC,BC,BC,BC,11 → 77 is dropped (no strobe, return to UNALIGNED). Lock is reached on the second BC run; data_out=11 is strobed once.
- Idle in ACTIVE, then reset: after lock send 22,BC,BC,44 → strobes for 22 and 44 only; data_out holds 22 across the BCs. Assert reset mid-byte after 44 → all outputs at reset values on the next edge, and 4 new BCs are needed to relock.
- With S2P_IDLE_CNT_EN: after lock send 300 BC bytes → idle_cnt=FF (saturated). The next reset → idle_cnt=00.

Source files
------------

// File: rtl/serial_to_parallel_align.sv
// serial_to_parallel_align
// Receive-side byte aligner for one serial lane. Bits arrive MSB first, one
// per clk_8f. The block hunts for the COMMA byte with a sliding bit search,
// confirms the byte boundary over LOCK_CNT consecutive aligned commas, then
// delivers every non-comma byte on data_out with a one-cycle valid_out strobe.
//
// Optional build macro: S2P_IDLE_CNT_EN adds idle_cnt, a saturating count of
// comma (idle) bytes observed at boundaries while ACTIVE.
//
// Output handshake: valid_out is a pure one-cycle strobe with no ready; a
// byte is taken by the consumer in the cycle valid_out is high, and data_out
// holds that byte until the next strobe.
module serial_to_parallel_align #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
`ifdef S2P_IDLE_CNT_EN
  ,
  output logic [7:0] idle_cnt
`endif
);

  localparam logic [1:0] ST_UNALIGNED = 2'd0;
  localparam logic [1:0] ST_ALIGNING  = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic [1:0] state_q, state_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic boundary;
  logic is_comma;

  // A boundary is the cycle where sr holds a complete aligned byte.
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_comma = (sr_q == COMMA);

  // Next-state logic: shifting, boundary tracking, lock FSM and output capture.
  always_comb begin
    sr_d       = {sr_q[6:0], data_in};
    bit_cnt_d  = bit_cnt_q + 3'd1;
    lock_cnt_d = lock_cnt_q;
    state_d    = state_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_UNALIGNED: begin
        // Sliding search: any cycle holding a comma defines the boundary phase.
        if (is_comma) begin
          bit_cnt_d  = 3'd0;
          lock_cnt_d = 4'd1;
          state_d    = (LOCK_TGT == 4'd1) ? ST_ACTIVE : ST_ALIGNING;
        end
      end
      ST_ALIGNING: begin
        if (boundary) begin
          if (is_comma) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
            if ((lock_cnt_q + 4'd1) == LOCK_TGT) begin
              state_d = ST_ACTIVE;
            end
          end else begin
            lock_cnt_d = 4'd0;
            state_d    = ST_UNALIGNED;
          end
        end
      end
      ST_ACTIVE: begin
        // Commas are idle fill and are never delivered as data.
        if (boundary && !is_comma) begin
          data_out_d = sr_q;
          valid_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNALIGNED;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      lock_cnt_q <= 4'd0;
      state_q    <= ST_UNALIGNED;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign active    = active_q;

`ifdef S2P_IDLE_CNT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  // Count idle commas seen at ACTIVE boundaries, saturating at 8'hFF.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q == ST_ACTIVE) && boundary && is_comma && (idle_cnt_q != 8'hFF)) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  // Idle counter register, cleared only by reset.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      idle_cnt_q <= 8'h00;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_align.sv
// Testbench for serial_to_parallel_align: directed scenarios plus randomized
// lock/data runs, checked every cycle against a bit-history reference model
// and a scoreboard of expected delivered bytes.
module tb_serial_to_parallel_align;

  localparam int         LOCK_CNT = 4;
  localparam logic [7:0] COMMA    = 8'hBC;

  // ---------------- clock / reset ----------------
  logic       clk_8f = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
`ifdef S2P_IDLE_CNT_EN
  logic [7:0] idle_cnt;
`endif

  always #5 clk_8f = ~clk_8f;

  serial_to_parallel_align #(.COMMA(COMMA), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
`ifdef S2P_IDLE_CNT_EN
    ,
    .idle_cnt (idle_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the raw bit history and absolute cycle numbers: a byte boundary
  // is "8 cycles after the last one", and lock is a run length of commas.
  bit         hist[$];
  int         m_mode;      // 0 searching, 1 confirming, 2 locked
  int         m_run;
  int         m_cyc;
  int         m_next;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_active;
  int         m_idle;

  function automatic logic [7:0] window();
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (hist.size() > i) w[i] = hist[hist.size() - 1 - i];
    end
    return w;
  endfunction

  task automatic model_step(input logic rst, input logic b);
    logic [7:0] w;
    if (rst) begin
      hist.delete();
      m_mode = 0; m_run = 0; m_cyc = 0; m_next = 0;
      m_dout = 8'h00; m_valid = 1'b0; m_active = 1'b0; m_idle = 0;
    end else begin
      w = window();
      m_valid = 1'b0;
      if (m_mode == 0) begin
        if (w == COMMA) begin
          m_run  = 1;
          m_next = m_cyc + 8;
          m_mode = (LOCK_CNT == 1) ? 2 : 1;
        end
      end else if (m_cyc == m_next) begin
        m_next = m_next + 8;
        if (m_mode == 1) begin
          if (w == COMMA) begin
            m_run++;
            if (m_run == LOCK_CNT) m_mode = 2;
          end else begin
            m_run  = 0;
            m_mode = 0;
          end
        end else begin
          if (w != COMMA) begin
            m_dout  = w;
            m_valid = 1'b1;
          end else if (m_idle < 255) begin
            m_idle++;
          end
        end
      end
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
      m_cyc++;
      m_active = (m_mode == 2);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs are sampled on the falling edge, then the next input is applied.
  task automatic drive_bit(input logic rst, input logic b);
    @(negedge clk_8f);
    if (chk_en) begin
      check_eq("data_out", data_out, m_dout);
      check_eq("valid_out", valid_out, m_valid);
      check_eq("active", active, m_active);
`ifdef S2P_IDLE_CNT_EN
      check_eq("idle_cnt", idle_cnt, m_idle);
`endif
      if (valid_out === 1'b1) begin
        check_eq("sb_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("sb_data", data_out, exp_q.pop_front());
      end
    end
    reset   = rst;
    data_in = b;
    model_step(rst, b);
    chk_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(1'b0, v[i]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(COMMA);
  endtask

  // Trailing idle so the last strobe is observed, then the queue must be drained.
  task automatic flush(input string tag);
    send_byte(COMMA);
    drive_bit(1'b0, 1'b1);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nj;
    int nb;
    logic [7:0] v;

    // Reset held 3 clocks with random data, then first clock after release.
    do_reset(3);
    drive_bit(1'b0, 1'b1);
    check_eq("rst_active", active, 1'b0);
    check_eq("rst_data", data_out, 8'h00);

    // Aligned lock.
    do_reset(2);
    send_commas(4);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    send_byte(8'hA5); send_byte(8'h3C);
    flush("aligned_drain");

    // Misaligned start.
    do_reset(2);
    drive_bit(1'b0, 1'b1); drive_bit(1'b0, 1'b0); drive_bit(1'b0, 1'b1);
    send_commas(4);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    flush("misaligned_drain");

    // Broken lock: 77 is dropped, lock on the second comma run.
    do_reset(2);
    send_commas(3);
    send_byte(8'h77);
    send_commas(4);
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    flush("broken_drain");

    // Idle while ACTIVE, then reset mid-byte and relock.
    do_reset(2);
    send_commas(4);
    exp_q.push_back(8'h22); exp_q.push_back(8'h44);
    send_byte(8'h22); send_commas(2); send_byte(8'h44);
    send_byte(COMMA);
    drive_bit(1'b0, 1'b1); drive_bit(1'b0, 1'b0); drive_bit(1'b0, 1'b1);
    check_eq("idle_drain", exp_q.size(), 0);
    do_reset(1);
    send_commas(3);
    check_eq("relock_not_yet", active, 1'b0);
    send_commas(1);
    exp_q.push_back(8'h66);
    send_byte(8'h66);
    flush("relock_drain");

    // Randomized runs: junk offset, lock, random data with occasional idle.
    for (int r = 0; r < 6; r++) begin
      do_reset($urandom_range(1, 3));
      nj = $urandom_range(0, 7);
      for (int j = 0; j < nj; j++) drive_bit(1'b0, 1'($urandom_range(0, 1)));
      send_commas(LOCK_CNT);
      nb = $urandom_range(4, 12);
      for (int k = 0; k < nb; k++) begin
        v = ($urandom_range(0, 4) == 0) ? COMMA : 8'($urandom_range(0, 255));
        if (v != COMMA) exp_q.push_back(v);
        send_byte(v);
      end
      flush("rand_drain");
    end

`ifdef S2P_IDLE_CNT_EN
    // Idle counter saturation and reset clear.
    do_reset(2);
    send_commas(4);
    send_commas(300);
    drive_bit(1'b0, 1'b1); drive_bit(1'b0, 1'b0);
    check_eq("idle_sat", idle_cnt, 8'hFF);
    do_reset(1);
    drive_bit(1'b0, 1'b0);
    check_eq("idle_clr", idle_cnt, 8'h00);
`endif

    drive_bit(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
